// File: rtl/adder_nios_debug_pkg.sv
// Shared types and jdo field positions for the Nios debug on-chip memory controller.
package adder_nios_debug_pkg;

  // JTAG command waiting to be executed against the debug RAM.
  typedef enum logic [1:0] {
    JREQ_NONE = 2'd0,
    JREQ_RD   = 2'd1,
    JREQ_WR   = 2'd2
  } jreq_t;

  // Controller state: idle, JTAG read in flight, CPU read in flight.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    J_RDW = 2'd1,
    C_RDW = 2'd2
  } state_t;

  localparam int JDO_W          = 38;
  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_WDATA_LSB  = 3;
  localparam int JDO_RDLOAD_BIT = 34;

endpackage

// File: rtl/adder_nios_debug_ram.sv
// Single-port synchronous RAM with byte enables and one cycle of read latency.
// Written so synthesis maps it onto a block RAM; the array carries no reset.
module adder_nios_debug_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // One access per cycle: byte-enabled write, or read into the output register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be[b]) begin
            mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        q <= mem_r[addr];
      end
    end
  end

endmodule

// File: rtl/adder_nios_debug_ocimem_ctrl.sv
// Debug on-chip memory controller: executes JTAG load/read/write commands through
// MonAReg/MonDReg and serves the CPU Avalon-MM slave, sharing one single-port RAM
// with JTAG commands taking precedence over new CPU accesses.
module adder_nios_debug_ocimem_ctrl
  import adder_nios_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  localparam logic [ADDR_W-1:0]   ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W/8-1:0] BE_ALL   = {(DATA_W/8){1'b1}};
  localparam logic [DATA_W/8-1:0] BE_NONE  = {(DATA_W/8){1'b0}};

  state_t              state_r, state_s;
  jreq_t               pending_r, pending_s;
  logic [ADDR_W-1:0]   mon_a_reg_r, mon_a_reg_s;
  logic [DATA_W-1:0]   wbuf_r, wbuf_s;
  logic                error_s;
  logic                rd_done_r;

  logic                ram_en_s, ram_we_s;
  logic [DATA_W/8-1:0] ram_be_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_wdata_s, ram_q_s;

  logic                jtag_done_s, mond_load_s, rdata_load_s;
  logic                cpu_rd_done_s, cpu_wr_grant_s;
  logic                unused_jdo_s;

  assign unused_jdo_s = ^{jdo[JDO_W-1:JDO_RDLOAD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  adder_nios_debug_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .be    (ram_be_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .q     (ram_q_s)
  );

  // FSM next state and RAM port arbitration; a completed CPU read occupies no RAM slot.
  always_comb begin
    state_s        = state_r;
    ram_en_s       = 1'b0;
    ram_we_s       = 1'b0;
    ram_be_s       = BE_NONE;
    ram_addr_s     = mon_a_reg_r;
    ram_wdata_s    = wbuf_r;
    jtag_done_s    = 1'b0;
    mond_load_s    = 1'b0;
    rdata_load_s   = 1'b0;
    cpu_rd_done_s  = 1'b0;
    cpu_wr_grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_done_r && avs_read) begin
          cpu_rd_done_s = 1'b1;
        end else begin
          cpu_rd_done_s = 1'b0;
        end
        if (pending_r == JREQ_WR) begin
          ram_en_s    = 1'b1;
          ram_we_s    = 1'b1;
          ram_be_s    = BE_ALL;
          jtag_done_s = 1'b1;
        end else if (pending_r == JREQ_RD) begin
          ram_en_s = 1'b1;
          state_s  = J_RDW;
        end else if (!rd_done_r && avs_write) begin
          ram_en_s       = 1'b1;
          ram_we_s       = 1'b1;
          ram_be_s       = avs_byteenable;
          ram_addr_s     = avs_address;
          ram_wdata_s    = avs_writedata;
          cpu_wr_grant_s = 1'b1;
        end else if (!rd_done_r && avs_read) begin
          ram_en_s   = 1'b1;
          ram_addr_s = avs_address;
          state_s    = C_RDW;
        end else begin
          state_s = IDLE;
        end
      end
      J_RDW: begin
        mond_load_s = 1'b1;
        jtag_done_s = 1'b1;
        state_s     = IDLE;
      end
      C_RDW: begin
        rdata_load_s = 1'b1;
        state_s      = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Strobe capture into the pending slot, address register updates and overrun flag.
  always_comb begin
    pending_s   = pending_r;
    mon_a_reg_s = mon_a_reg_r;
    wbuf_s      = wbuf_r;
    error_s     = monitor_error;
    if (pending_r == JREQ_NONE) begin
      if (take_action_ocimem_a) begin
        mon_a_reg_s = jdo[JDO_ADDR_LSB +: ADDR_W];
        pending_s   = jdo[JDO_RDLOAD_BIT] ? JREQ_RD : JREQ_NONE;
        error_s     = take_action_ocimem_b | take_no_action_ocimem_a;
      end else if (take_action_ocimem_b) begin
        pending_s = JREQ_WR;
        wbuf_s    = jdo[JDO_WDATA_LSB +: DATA_W];
        error_s   = monitor_error | take_no_action_ocimem_a;
      end else if (take_no_action_ocimem_a) begin
        pending_s = JREQ_RD;
      end else begin
        pending_s = JREQ_NONE;
      end
    end else begin
      if (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a) begin
        error_s = 1'b1;
      end else begin
        error_s = monitor_error;
      end
      if (jtag_done_s) begin
        pending_s   = JREQ_NONE;
        mon_a_reg_s = mon_a_reg_r + ADDR_ONE;
      end else begin
        pending_s = pending_r;
      end
    end
  end

  // Avalon stall: any CPU request not granted this very cycle waits.
  assign avs_waitrequest = (avs_read | avs_write) & ~(cpu_rd_done_s | cpu_wr_grant_s);

  // Controller state, JTAG registers and registered status/read-data outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      pending_r     <= JREQ_NONE;
      mon_a_reg_r   <= {ADDR_W{1'b0}};
      wbuf_r        <= {DATA_W{1'b0}};
      MonDReg       <= {DATA_W{1'b0}};
      avs_readdata  <= {DATA_W{1'b0}};
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      rd_done_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      pending_r     <= pending_s;
      mon_a_reg_r   <= mon_a_reg_s;
      wbuf_r        <= wbuf_s;
      monitor_error <= error_s;
      monitor_ready <= (pending_s == JREQ_NONE) && (state_s != J_RDW);
      rd_done_r     <= (state_r == C_RDW);
      if (mond_load_s) begin
        MonDReg <= ram_q_s;
      end
      if (rdata_load_s) begin
        avs_readdata <= ram_q_s;
      end
    end
  end

endmodule

// File: tb/tb_adder_nios_debug_ocimem_ctrl.sv
// Scoreboard bench for the debug on-chip memory controller: stimulus pushes the
// expected CPU read data and post-command MonDReg values into queues; a monitor
// pops and compares when a CPU read completes or monitor_ready rises.
module tb_adder_nios_debug_ocimem_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;

  always #5 clk = ~clk;

  adder_nios_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] jtag_q[$];
  logic        prev_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare completed CPU reads and finished JTAG commands against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (avs_read && !avs_waitrequest) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected: got %h expected no read completion", avs_readdata);
        end else begin
          check("cpu_rdata", avs_readdata, cpu_q.pop_front());
        end
      end
      if (monitor_ready && !prev_ready) begin
        if (jtag_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL jtag_unexpected: got MonDReg %h expected no completion", MonDReg);
        end else begin
          check("jtag_mondreg", MonDReg, jtag_q.pop_front());
        end
      end
    end
    prev_ready = monitor_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_load(input logic [7:0] a, input logic rd);
    logic [37:0] w;
    w = 38'd0;
    w[24:17] = a;
    w[34] = rd;
    return w;
  endfunction

  function automatic logic [37:0] jdo_wr(input logic [31:0] d);
    logic [37:0] w;
    w = 38'd0;
    w[34:3] = d;
    return w;
  endfunction

  // kind: 0 = action_a, 1 = no_action_a, 2 = action_b
  task automatic jtag_cmd(input int kind, input logic [37:0] word);
    jdo = word;
    case (kind)
      0: take_action_ocimem_a = 1'b1;
      1: take_no_action_ocimem_a = 1'b1;
      default: take_action_ocimem_b = 1'b1;
    endcase
    step();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!monitor_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_timeout", {31'd0, monitor_ready}, 32'd1);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cpu_wr_timeout", {31'd0, avs_waitrequest}, 32'd0);
    step();
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, output int cycles);
    cpu_q.push_back(exp);
    avs_address = a; avs_read = 1'b1;
    cycles = 1;
    @(negedge clk);
    while (avs_waitrequest && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    step();
    avs_read = 1'b0;
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; jdo = 38'd0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = 8'd0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'd0; avs_byteenable = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_ready", {31'd0, monitor_ready}, 32'd1);
    check("rst_error", {31'd0, monitor_error}, 32'd0);
    check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
    reset_n = 1'b1;
    step();

    // JTAG writes: 0x10 <= DEADBEEF, then post-incremented 0x11 <= 11111111
    jtag_cmd(0, jdo_load(8'h10, 1'b0));
    jtag_q.push_back(32'h0000_0000);
    jtag_cmd(2, jdo_wr(32'hDEAD_BEEF));
    check("wr_ready_drop", {31'd0, monitor_ready}, 32'd0);
    wait_ready();
    jtag_q.push_back(32'h0000_0000);
    jtag_cmd(2, jdo_wr(32'h1111_1111));
    wait_ready();

    // Load address with read: MonDReg valid two cycles after capture
    jtag_q.push_back(32'hDEAD_BEEF);
    jtag_cmd(0, jdo_load(8'h10, 1'b1));
    check("rd_ready_c0", {31'd0, monitor_ready}, 32'd0);
    step();
    check("rd_ready_c1", {31'd0, monitor_ready}, 32'd0);
    step();
    check("rd_lat_mondreg", MonDReg, 32'hDEAD_BEEF);
    check("rd_lat_ready", {31'd0, monitor_ready}, 32'd1);
    jtag_q.push_back(32'h1111_1111);
    jtag_cmd(1, 38'd0);
    wait_ready();

    // Address wrap 0xFF -> 0x00 on write and on read
    jtag_cmd(0, jdo_load(8'hFF, 1'b0));
    jtag_q.push_back(32'h1111_1111);
    jtag_cmd(2, jdo_wr(32'hCAFE_F00D));
    wait_ready();
    jtag_q.push_back(32'h1111_1111);
    jtag_cmd(2, jdo_wr(32'h0123_4567));
    wait_ready();
    jtag_cmd(0, jdo_load(8'hFF, 1'b0));
    jtag_q.push_back(32'hCAFE_F00D);
    jtag_cmd(1, 38'd0);
    wait_ready();
    jtag_q.push_back(32'h0123_4567);
    jtag_cmd(1, 38'd0);
    wait_ready();
    check("wrap_error", {31'd0, monitor_error}, 32'd0);

    // Overrun: write strobe one cycle after a read strobe is dropped
    jtag_cmd(0, jdo_load(8'h10, 1'b0));
    jtag_q.push_back(32'hDEAD_BEEF);
    jtag_cmd(1, 38'd0);
    jtag_cmd(2, jdo_wr(32'hBAD0_BAD0));
    check("drop_error", {31'd0, monitor_error}, 32'd1);
    wait_ready();
    jtag_q.push_back(32'h1111_1111);
    jtag_cmd(0, jdo_load(8'h11, 1'b1));
    check("clear_error", {31'd0, monitor_error}, 32'd0);
    wait_ready();

    // Simultaneous strobes: action_a wins, the other is dropped
    jdo = jdo_load(8'h20, 1'b0);
    take_action_ocimem_a = 1'b1; take_no_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0;
    check("multi_error", {31'd0, monitor_error}, 32'd1);
    check("multi_ready", {31'd0, monitor_ready}, 32'd1);
    jtag_cmd(0, jdo_load(8'h40, 1'b0));
    check("multi_clear", {31'd0, monitor_error}, 32'd0);

    // CPU byte-enabled write and minimum-latency read
    cpu_write(8'h40, 32'h1122_3344, 4'b1111);
    cpu_write(8'h40, 32'hAABB_CCDD, 4'b0010);
    cpu_read(8'h40, 32'h1122_CC44, cyc);
    check("cpu_rd_cycles", cyc, 32'd3);
    cpu_read(8'h11, 32'h1111_1111, cyc);

    // CPU read held behind a pending JTAG write returns post-write data
    jtag_cmd(0, jdo_load(8'h10, 1'b0));
    jtag_q.push_back(32'h1111_1111);
    jtag_cmd(2, jdo_wr(32'h5A5A_1234));
    cpu_read(8'h10, 32'h5A5A_1234, cyc);
    check("stall_rd_cycles", cyc, 32'd4);

    // Reset in the middle of a CPU read
    avs_address = 8'h40; avs_read = 1'b1;
    step();
    reset_n = 1'b0; avs_read = 1'b0;
    #1;
    check("midrst_readdata", avs_readdata, 32'd0);
    check("midrst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
    check("midrst_mondreg", MonDReg, 32'd0);
    check("midrst_ready", {31'd0, monitor_ready}, 32'd1);
    check("midrst_error", {31'd0, monitor_error}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    cpu_read(8'h40, 32'h1122_CC44, cyc);
    check("post_rst_cycles", cyc, 32'd3);

    repeat (2) step();
    check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("jtag_q_empty", 32'(jtag_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
